axis_port_arbiter: RTL and testbench

Packet-granular round-robin arbiter and mux for one AXI-Stream output port of the NoC router. It shares a single output link among `NUM_IN` input streams and holds the grant for a whole packet, from the first beat through the `tlast` beat. The winning stream passes through a one-entry registered output slice. One instance sits in front of each router output port, in the `clk_noc` domain.

---
 rtl/axis_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_axis_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axis_port_arbiter.sv
// rtl/axis_port_arbiter.sv - packet-granular round-robin arbiter with a one-entry registered AXIS output slice
module axis_port_arbiter #(
    parameter int NUM_IN = 5,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2,
    parameter int DEST_W = 4
) (
    input  logic                       clk_noc,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          in_tvalid,
    output logic [NUM_IN-1:0]          in_tready,
    input  logic [NUM_IN*DATA_W-1:0]   in_tdata,
    input  logic [NUM_IN-1:0]          in_tlast,
    input  logic [NUM_IN*ID_W-1:0]     in_tid,
    input  logic [NUM_IN*DEST_W-1:0]   in_tdest,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic [DATA_W-1:0]          out_tdata,
    output logic                       out_tlast,
    output logic [ID_W-1:0]            out_tid,
    output logic [DEST_W-1:0]          out_tdest,
    output logic [NUM_IN-1:0]          grant,
    output logic                       busy
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_IN-1:0]   grant_q, grant_d;
    logic                out_tvalid_q, out_tvalid_d;
    logic [DATA_W-1:0]   out_tdata_q, out_tdata_d;
    logic                out_tlast_q, out_tlast_d;
    logic [ID_W-1:0]     out_tid_q, out_tid_d;
    logic [DEST_W-1:0]   out_tdest_q, out_tdest_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic                slice_ready;
    logic                accept;
    logic [DATA_W-1:0]   sel_tdata;
    logic                sel_tlast;
    logic [ID_W-1:0]     sel_tid;
    logic [DEST_W-1:0]   sel_tdest;

    // First requester after the previous owner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_IN);
            if (!win_found && in_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        slice_ready = !out_tvalid_q || out_tready;
        in_tready   = (state_q == LOCKED && slice_ready) ? grant_q : '0;
        accept      = |(in_tvalid & in_tready);
        sel_tdata   = in_tdata[int'(owner_q)*DATA_W +: DATA_W];
        sel_tlast   = in_tlast[owner_q];
        sel_tid     = in_tid[int'(owner_q)*ID_W +: ID_W];
        sel_tdest   = in_tdest[int'(owner_q)*DEST_W +: DEST_W];
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        out_tid_d    = out_tid_q;
        out_tdest_d  = out_tdest_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = LOCKED;
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                end
            end
            LOCKED: begin
                if (accept && sel_tlast) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q;
                    grant_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load wins over a drain so take-and-load keeps the slice full.
        if (accept) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = sel_tdata;
            out_tlast_d  = sel_tlast;
            out_tid_d    = sel_tid;
            out_tdest_d  = sel_tdest;
        end else if (out_tvalid_q && out_tready) begin
            out_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDX_W'(NUM_IN - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tid_q    <= '0;
            out_tdest_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
            out_tid_q    <= out_tid_d;
            out_tdest_q  <= out_tdest_d;
        end
    end

    assign out_tvalid = out_tvalid_q;
    assign out_tdata  = out_tdata_q;
    assign out_tlast  = out_tlast_q;
    assign out_tid    = out_tid_q;
    assign out_tdest  = out_tdest_q;
    assign grant      = grant_q;
    assign busy       = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_port_arbiter.sv
// tb/tb_axis_port_arbiter.sv - directed table-driven bench for axis_port_arbiter
module tb_axis_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int TW = 4;

    logic              clk_noc = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      in_tvalid = '0;
    logic [N-1:0]      in_tready;
    logic [N*DW-1:0]   in_tdata = '0;
    logic [N-1:0]      in_tlast = '0;
    logic [N*IW-1:0]   in_tid = '0;
    logic [N*TW-1:0]   in_tdest = '0;
    logic              out_tvalid;
    logic              out_tready = 1'b1;
    logic [DW-1:0]     out_tdata;
    logic              out_tlast;
    logic [IW-1:0]     out_tid;
    logic [TW-1:0]     out_tdest;
    logic [N-1:0]      grant;
    logic              busy;

    axis_port_arbiter #(.NUM_IN(N), .DATA_W(DW), .ID_W(IW), .DEST_W(TW)) dut (
        .clk_noc(clk_noc), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tlast(in_tlast), .in_tid(in_tid), .in_tdest(in_tdest),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tlast(out_tlast), .out_tid(out_tid), .out_tdest(out_tdest),
        .grant(grant), .busy(busy)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        logic        r;
        logic [4:0]  vld;
        logic [4:0]  lst;
        logic [7:0]  d;
        logic        ordy;
        logic        chk;
        logic [4:0]  g;
        logic        bsy;
        logic [4:0]  trdy;
        logic        ov;
        logic [31:0] od;
        logic        ol;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   row    = 0;

    function automatic vec_t mk(input logic r, input logic [4:0] vld, input logic [4:0] lst,
                                input logic [7:0] d, input logic ordy, input logic chk,
                                input logic [4:0] g, input logic bsy, input logic [4:0] trdy,
                                input logic ov, input logic [31:0] od, input logic ol);
        vec_t v;
        v.r = r; v.vld = vld; v.lst = lst; v.d = d; v.ordy = ordy; v.chk = chk;
        v.g = g; v.bsy = bsy; v.trdy = trdy; v.ov = ov; v.od = od; v.ol = ol;
        return v;
    endfunction

    function automatic vec_t rst_row();
        return mk(1'b1, 5'b0, 5'b0, 8'h00, 1'b1, 1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 32'h0, 1'b0);
    endfunction

    // Expected beat as seen on the output: stream index in bits [15:8], data byte below.
    function automatic logic [31:0] pk(input int s, input int d);
        return 32'(((s & 255) << 8) | (d & 255));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    endtask

    task automatic step(input vec_t v);
        logic [1:0] e_tid;
        logic [3:0] e_tdest;
        @(negedge clk_noc);
        rst        = v.r;
        in_tvalid  = v.vld;
        in_tlast   = v.lst;
        out_tready = v.ordy;
        for (int i = 0; i < N; i++) begin
            in_tdata[i*DW +: DW] = {16'h0, 8'(i), v.d};
            in_tid[i*IW +: IW]   = 2'(i);
            in_tdest[i*TW +: TW] = 4'(i + 1);
        end
        #1;
        if (v.chk) begin
            check("grant", 32'(grant), 32'(v.g));
            check("busy", 32'(busy), 32'(v.bsy));
            check("in_tready", 32'(in_tready), 32'(v.trdy));
            check("out_tvalid", 32'(out_tvalid), 32'(v.ov));
            check("out_tdata", out_tdata, v.od);
            check("out_tlast", 32'(out_tlast), 32'(v.ol));
            if (v.ov) begin
                e_tid   = v.od[9:8];
                e_tdest = 4'(v.od[11:8] + 4'd1);
                check("out_tid", 32'(out_tid), 32'(e_tid));
                check("out_tdest", 32'(out_tdest), 32'(e_tdest));
            end
        end
        row++;
    endtask

    initial begin
        int o, po, d1;
        // Stream 2, three-beat packet
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 8'hA0, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 8'hA0, 1, 1, 5'b00100, 1, 5'b00100, 0, 32'h000, 0));
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 8'hA1, 1, 1, 5'b00100, 1, 5'b00100, 1, 32'h2A0, 0));
        tbl.push_back(mk(0, 5'b00100, 5'b00100, 8'hA2, 1, 1, 5'b00100, 1, 5'b00100, 1, 32'h2A1, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 8'hA3, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h2A2, 1));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 8'hA3, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h2A2, 1));

        // All streams requesting two-beat packets: owners rotate 0,1,2,3,4,0,1
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 5'b11111, 5'b00000, 8'h40, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        for (int p = 0; p < 7; p++) begin
            o  = p % 5;
            po = (p + 4) % 5;
            d1 = 8'h40 + 3 * p + 1;
            tbl.push_back(mk(0, 5'b11111, 5'b00000, 8'(d1), 1, 1, 5'(1 << o), 1, 5'(1 << o), 0,
                             (p == 0) ? 32'h0 : pk(po, d1 - 2), p != 0));
            tbl.push_back(mk(0, 5'b11111, 5'(1 << o), 8'(d1 + 1), 1, 1, 5'(1 << o), 1, 5'(1 << o), 1,
                             pk(o, d1), 0));
            tbl.push_back(mk(0, 5'b11111, 5'b00000, 8'(d1 + 2), 1, 1, 5'b00000, 0, 5'b00000, 1,
                             pk(o, d1 + 1), 1));
        end

        // Stream 4 alone, single-beat packets back to back
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 8'h60, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        for (int t = 1; t <= 8; t++) begin
            if (t % 2 == 1)
                tbl.push_back(mk(0, 5'b10000, 5'b10000, 8'(8'h60 + t), 1, 1, 5'b10000, 1, 5'b10000, 0,
                                 (t == 1) ? 32'h0 : pk(4, 8'h60 + t - 2), t > 1));
            else
                tbl.push_back(mk(0, 5'b10000, 5'b10000, 8'(8'h60 + t), 1, 1, 5'b00000, 0, 5'b00000, 1,
                                 pk(4, 8'h60 + t - 1), 1));
        end

        @(posedge clk_noc);
        foreach (tbl[i]) step(tbl[i]);

        // Backpressure on stream 1 while stream 3 waits
        step(rst_row());
        step(mk(0, 5'b01010, 5'b00000, 8'h70, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        step(mk(0, 5'b01010, 5'b00000, 8'h70, 1, 1, 5'b00010, 1, 5'b00010, 0, 32'h000, 0));
        for (int k = 0; k < 4; k++)
            step(mk(0, 5'b01010, 5'b00000, 8'(8'h71 + k), 0, 1, 5'b00010, 1, 5'b00000, 1, 32'h170, 0));
        step(mk(0, 5'b01010, 5'b00010, 8'h75, 1, 1, 5'b00010, 1, 5'b00010, 1, 32'h170, 0));
        step(mk(0, 5'b01010, 5'b00000, 8'h76, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h175, 1));
        step(mk(0, 5'b01010, 5'b01000, 8'h78, 1, 1, 5'b01000, 1, 5'b01000, 0, 32'h175, 1));
        step(mk(0, 5'b00000, 5'b00000, 8'h79, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h378, 1));

        // Owner 0 stalls mid-packet while stream 4 requests
        step(rst_row());
        step(mk(0, 5'b10001, 5'b00000, 8'h80, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        step(mk(0, 5'b10001, 5'b00000, 8'h80, 1, 1, 5'b00001, 1, 5'b00001, 0, 32'h000, 0));
        step(mk(0, 5'b10000, 5'b00000, 8'h81, 1, 1, 5'b00001, 1, 5'b00001, 1, 32'h080, 0));
        step(mk(0, 5'b10000, 5'b00000, 8'h82, 1, 1, 5'b00001, 1, 5'b00001, 0, 32'h080, 0));
        step(mk(0, 5'b10000, 5'b00000, 8'h83, 1, 1, 5'b00001, 1, 5'b00001, 0, 32'h080, 0));
        step(mk(0, 5'b10001, 5'b00001, 8'h84, 1, 1, 5'b00001, 1, 5'b00001, 0, 32'h080, 0));
        step(mk(0, 5'b10000, 5'b00000, 8'h85, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h084, 1));
        step(mk(0, 5'b10000, 5'b10000, 8'h86, 1, 1, 5'b10000, 1, 5'b10000, 0, 32'h084, 1));
        step(mk(0, 5'b00000, 5'b00000, 8'h87, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h486, 1));

        // Reset during beat 2 of a stream 2 packet, then a fresh request from stream 3
        step(rst_row());
        step(mk(0, 5'b00100, 5'b00000, 8'h90, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        step(mk(0, 5'b00100, 5'b00000, 8'h90, 1, 1, 5'b00100, 1, 5'b00100, 0, 32'h000, 0));
        step(mk(1, 5'b00100, 5'b00000, 8'h91, 1, 1, 5'b00100, 1, 5'b00100, 1, 32'h290, 0));
        step(mk(0, 5'b01000, 5'b00000, 8'h92, 1, 1, 5'b00000, 0, 5'b00000, 0, 32'h000, 0));
        step(mk(0, 5'b01000, 5'b01000, 8'h93, 1, 1, 5'b01000, 1, 5'b01000, 0, 32'h000, 0));
        step(mk(0, 5'b00000, 5'b00000, 8'h94, 1, 1, 5'b00000, 0, 5'b00000, 1, 32'h393, 1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
